// File: rtl/pio_isr_if.sv
// Bus bundle between the PIO sequencer / pin sampler / RX FIFO and the input shift register.
interface pio_isr_if #(
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic             cfg_shiftRight;
  logic             cfg_autoPush;
  logic [CW-1:0]    cfg_pushThresh;
  logic [WIDTH-1:0] pin_data;
  logic             in_valid;
  logic [CW-1:0]    in_count;
  logic             push_req;
  logic             push_block;
  logic             clear;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_valid;
  logic             fifo_ready;
  logic             stall;
  logic [WIDTH-1:0] isr_value;
  logic [CW-1:0]    isr_count;

  modport slave (
    input  cfg_shiftRight, cfg_autoPush, cfg_pushThresh, pin_data, in_valid, in_count,
           push_req, push_block, clear, fifo_ready,
    output fifo_data, fifo_valid, stall, isr_value, isr_count
  );

  modport master (
    output cfg_shiftRight, cfg_autoPush, cfg_pushThresh, pin_data, in_valid, in_count,
           push_req, push_block, clear, fifo_ready,
    input  fifo_data, fifo_valid, stall, isr_value, isr_count
  );
endinterface

// File: rtl/pio_isr.sv
// PIO input shift register with PUSH/autopush into a single-entry RX output buffer.
// Optional macro PIO_ISR_DROP_COUNT_EN adds a saturating drop_count output.
module pio_isr #(
  parameter int WIDTH = 32
) (
  input  logic        clock,
  input  logic        reset,
`ifdef PIO_ISR_DROP_COUNT_EN
  output logic [15:0] drop_count,
`endif
  pio_isr_if.slave    bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] isr_q, isr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] fifo_data_q, fifo_data_d;

  logic [CW-1:0]    n_s, thr_s, cnt_new_s;
  logic [CW:0]      cnt_sum_s;
  logic [WIDTH-1:0] mask_s, d_s, isr_new_s;
  logic             do_in_s, do_push_s, auto_hit_s, slot_free_s;
  logic             stall_s, drop_s;

`ifdef PIO_ISR_DROP_COUNT_EN
  logic [15:0] drop_q, drop_d;
`endif

  // Next-state decode: shift datapath, priority clear > IN > PUSH, stall and buffer control.
  always_comb begin
    n_s   = (bus.in_count == '0) ? CW'(WIDTH) : bus.in_count;
    thr_s = (bus.cfg_pushThresh == '0) ? CW'(WIDTH) : bus.cfg_pushThresh;
    // A shift by the full width yields zero, so n=WIDTH gives an all-ones mask and isr'=d.
    mask_s = (WIDTH'(1) << n_s) - WIDTH'(1);
    d_s    = bus.pin_data & mask_s;
    if (bus.cfg_shiftRight) begin
      isr_new_s = (isr_q >> n_s) | (d_s << (CW'(WIDTH) - n_s));
    end else begin
      isr_new_s = (isr_q << n_s) | d_s;
    end
    cnt_sum_s = {1'b0, cnt_q} + {1'b0, n_s};
    cnt_new_s = (cnt_sum_s > (CW + 1)'(WIDTH)) ? CW'(WIDTH) : cnt_sum_s[CW-1:0];

    do_in_s     = !bus.clear && bus.in_valid;
    do_push_s   = !bus.clear && !bus.in_valid && bus.push_req;
    auto_hit_s  = bus.cfg_autoPush && (cnt_new_s >= thr_s);
    slot_free_s = (state_q == ST_IDLE) || bus.fifo_ready;
    stall_s     = (do_in_s && auto_hit_s && !slot_free_s) ||
                  (do_push_s && !slot_free_s && bus.push_block);
    drop_s      = do_push_s && !slot_free_s && !bus.push_block;

    isr_d       = isr_q;
    cnt_d       = cnt_q;
    fifo_data_d = fifo_data_q;
    state_d     = state_q;

    if (state_q == ST_FULL && bus.fifo_ready) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_q;
    end

    if (bus.clear) begin
      isr_d = '0;
      cnt_d = '0;
    end else if (do_in_s) begin
      if (!auto_hit_s) begin
        isr_d = isr_new_s;
        cnt_d = cnt_new_s;
      end else if (slot_free_s) begin
        fifo_data_d = isr_new_s;
        state_d     = ST_FULL;
        isr_d       = '0;
        cnt_d       = '0;
      end else begin
        isr_d = isr_q;
      end
    end else if (do_push_s) begin
      if (slot_free_s) begin
        fifo_data_d = isr_q;
        state_d     = ST_FULL;
        isr_d       = '0;
        cnt_d       = '0;
      end else if (!bus.push_block) begin
        isr_d = '0;
        cnt_d = '0;
      end else begin
        isr_d = isr_q;
      end
    end else begin
      isr_d = isr_q;
    end

`ifdef PIO_ISR_DROP_COUNT_EN
    if (bus.clear) begin
      drop_d = 16'h0000;
    end else if (drop_s && drop_q != 16'hFFFF) begin
      drop_d = drop_q + 16'h0001;
    end else begin
      drop_d = drop_q;
    end
`endif
  end

  // State registers, including the registered output buffer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      isr_q       <= '0;
      cnt_q       <= '0;
      fifo_data_q <= '0;
`ifdef PIO_ISR_DROP_COUNT_EN
      drop_q      <= 16'h0000;
`endif
    end else begin
      state_q     <= state_d;
      isr_q       <= isr_d;
      cnt_q       <= cnt_d;
      fifo_data_q <= fifo_data_d;
`ifdef PIO_ISR_DROP_COUNT_EN
      drop_q      <= drop_d;
`endif
    end
  end

  assign bus.fifo_data  = fifo_data_q;
  assign bus.fifo_valid = (state_q == ST_FULL);
  assign bus.stall      = stall_s;
  assign bus.isr_value  = isr_q;
  assign bus.isr_count  = cnt_q;

`ifdef PIO_ISR_DROP_COUNT_EN
  assign drop_count = drop_q;
`else
  logic unused_drop_s;
  assign unused_drop_s = drop_s;
`endif
endmodule

// File: tb/tb_pio_isr.sv
// Directed + randomized bench for pio_isr against a 64-bit arithmetic reference model.
module tb_pio_isr;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pio_isr_if #(.WIDTH(32)) bus ();
`ifdef PIO_ISR_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  pio_isr #(.WIDTH(32)) u_dut (
    .clock      (clock),
    .reset      (reset),
`ifdef PIO_ISR_DROP_COUNT_EN
    .drop_count (drop_count),
`endif
    .bus        (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  longint unsigned m_isr, m_fd;
  int              m_cnt, m_drop;
  bit              m_fv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_isr = 0; m_fd = 0; m_cnt = 0; m_drop = 0; m_fv = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_isr"}, bus.isr_value, m_isr[31:0]);
    chk({tag, "_cnt"}, 32'(bus.isr_count), 32'(m_cnt));
    chk({tag, "_fv"}, 32'(bus.fifo_valid), 32'(m_fv));
    chk({tag, "_fd"}, bus.fifo_data, m_fd[31:0]);
`ifdef PIO_ISR_DROP_COUNT_EN
    chk({tag, "_drop"}, 32'(drop_count), 32'(m_drop));
`endif
  endtask

  // One clock: check stall against the model, take the edge, then check registered state.
  task automatic step(input string tag);
    longint unsigned d, nisr, word;
    int n, t, ncnt;
    bit fr, e_stall, pw;
    #1;
    n = (bus.in_count == 6'd0) ? 32 : int'(bus.in_count);
    t = (bus.cfg_pushThresh == 6'd0) ? 32 : int'(bus.cfg_pushThresh);
    d = 64'(bus.pin_data) & ((64'd1 << n) - 64'd1);
    if (bus.cfg_shiftRight) nisr = ((m_isr >> n) | (d << (32 - n))) & 64'hFFFF_FFFF;
    else                    nisr = ((m_isr << n) | d) & 64'hFFFF_FFFF;
    ncnt = (m_cnt + n > 32) ? 32 : m_cnt + n;
    fr = !m_fv || bus.fifo_ready;
    e_stall = 0; pw = 0; word = 0;
    chk({tag, "_stall"}, 32'(bus.stall), 32'(
        !bus.clear && ((bus.in_valid && bus.cfg_autoPush && ncnt >= t && !fr) ||
                       (!bus.in_valid && bus.push_req && bus.push_block && !fr))));
    @(posedge clock);
    if (bus.clear) begin
      m_isr = 0; m_cnt = 0; m_drop = 0;
    end else if (bus.in_valid) begin
      if (bus.cfg_autoPush && ncnt >= t) begin
        if (fr) begin pw = 1; word = nisr; m_isr = 0; m_cnt = 0; end
        else e_stall = 1;
      end else begin
        m_isr = nisr; m_cnt = ncnt;
      end
    end else if (bus.push_req) begin
      if (fr) begin pw = 1; word = m_isr; m_isr = 0; m_cnt = 0; end
      else if (!bus.push_block) begin
        m_isr = 0; m_cnt = 0;
        if (m_drop < 65535) m_drop++;
      end else e_stall = 1;
    end
    if (pw) begin m_fv = 1; m_fd = word; end
    else if (m_fv && bus.fifo_ready) m_fv = 0;
    #1;
    check_state(tag);
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.push_req = 0; bus.clear = 0; bus.push_block = 0;
  endtask

  task automatic do_in(input logic [31:0] pin, input logic [5:0] cnt);
    bus.pin_data = pin; bus.in_count = cnt; bus.in_valid = 1;
    bus.push_req = 0; bus.clear = 0;
  endtask

  initial begin
    bus.cfg_shiftRight = 0; bus.cfg_autoPush = 0; bus.cfg_pushThresh = 6'd0;
    bus.pin_data = 32'd0; bus.in_count = 6'd0; bus.fifo_ready = 0;
    idle();
    model_reset();
    #1;
    check_state("reset");
    #10 reset = 0;
    @(posedge clock); #1;

    // Shift left, no autopush
    do_in(32'h000000AB, 6'd8); step("t1a");
    do_in(32'hFFFFFFCD, 6'd8); step("t1b");
    chk("t1_isr_const", bus.isr_value, 32'h0000ABCD);
    chk("t1_cnt_const", 32'(bus.isr_count), 32'd16);

    // Full-word IN with autopush at threshold 32
    bus.cfg_autoPush = 1; bus.cfg_pushThresh = 6'd0;
    do_in(32'hDEADBEEF, 6'd0); step("t3");
    chk("t3_fd_const", bus.fifo_data, 32'hDEADBEEF);
    idle(); bus.fifo_ready = 1; step("t3_drain");

    // Shift right, autopush T=8
    bus.fifo_ready = 0; bus.cfg_shiftRight = 1; bus.cfg_pushThresh = 6'd8;
    do_in(32'h00000003, 6'd4); step("t2a");
    do_in(32'hFFFFFFF5, 6'd4); step("t2b");
    chk("t2_fd_const", bus.fifo_data, 32'h53000000);

    // Backpressure: autopush IN held while buffer occupied
    do_in(32'h000000FF, 6'd8);
    for (int i = 0; i < 3; i++) step("bp_hold");
    bus.fifo_ready = 1; step("bp_pass");
    chk("bp_fd_const", bus.fifo_data, 32'hFF000000);

    // Drop on non-blocking PUSH, then blocking PUSH stalls
    bus.fifo_ready = 0; bus.cfg_autoPush = 0;
    do_in(32'h00000007, 6'd4); step("drop_fill");
    idle(); bus.push_req = 1; bus.push_block = 0; step("drop_push");
    chk("drop_fd_const", bus.fifo_data, 32'hFF000000);
    do_in(32'h00000009, 6'd4); step("blk_fill");
    idle(); bus.push_req = 1; bus.push_block = 1; step("blk_push");

    // Reset mid-handshake with a pending word and ISR loaded
    idle(); bus.cfg_shiftRight = 0; bus.clear = 1; step("rst_clr");
    do_in(32'h00001234, 6'd16); step("rst_fill");
    chk("rst_fv_pre", 32'(bus.fifo_valid), 32'd1);
    idle();
    #2 reset = 1;
    #1 model_reset();
    check_state("rst_async");
    #1 reset = 0;
    @(posedge clock); #1;
    do_in(32'h0000ABCD, 6'd16); step("clr_fill");
    bus.clear = 1; step("clr_in");
    chk("clr_isr_const", bus.isr_value, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.cfg_shiftRight = 1'($urandom_range(0, 1));
      bus.cfg_autoPush   = 1'($urandom_range(0, 1));
      bus.cfg_pushThresh = 6'($urandom_range(0, 32));
      bus.pin_data       = $urandom;
      bus.in_count       = 6'($urandom_range(0, 32));
      bus.in_valid       = ($urandom_range(0, 99) < 50);
      bus.push_req       = ($urandom_range(0, 99) < 35);
      bus.push_block     = 1'($urandom_range(0, 1));
      bus.clear          = ($urandom_range(0, 99) < 4);
      bus.fifo_ready     = ($urandom_range(0, 99) < 45);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pio_isr.md
Name: pio_isr

Overview:
Input shift register stage of the PIO state machine, directly downstream of the pin-sampling block. It consumes the masked, base-shifted input word produced each cycle from the GPIO pins. On IN instructions it shifts the selected number of bits into the ISR. It hands completed words to the RX FIFO via explicit PUSH or autopush, with a single-entry output buffer and valid/ready handshake.

Parameters:
WIDTH, 32, ISR and FIFO word width; counts use clog2(WIDTH)+1 bits (6 at default).

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
cfg_shiftRight  in  1  1 = shift right (new bits enter at MSB); 0 = shift left (new bits enter at LSB)
cfg_autoPush  in  1  enable autopush
cfg_pushThresh  in  6  autopush threshold; 1..32, 0 encodes 32
pin_data  in  32  sampled pin word from the pin-sampling stage (already masked and base-aligned)
in_valid  in  1  execute IN this cycle
in_count  in  6  bits to shift; 1..32, 0 encodes 32
push_req  in  1  execute explicit PUSH this cycle
push_block  in  1  PUSH blocks (stalls) when output buffer occupied
clear  in  1  zero ISR and shift count
fifo_data  out  32  word offered to RX FIFO
fifo_valid  out  1  fifo_data valid
fifo_ready  in  1  RX FIFO accepts fifo_data
stall  out  1  current instruction cannot complete; sequencer must hold and re-present it
isr_value  out  32  current ISR contents
isr_count  out  6  current shift count, 0..32

Behaviour:
- Reset (async, any time incl. mid-handshake): isr_value=0, isr_count=0, fifo_data=0, fifo_valid=0; pending word lost.
- n = in_count, with 0 mapped to 32; T = cfg_pushThresh, with 0 mapped to 32; d = pin_data & ((1<<n)-1).
- Shift left: isr' = (isr << n) | d. Shift right: isr' = (isr >> n) | (d << (32-n)). n=32 gives isr' = d in both directions. Shifts are computed in 64-bit width to avoid shift-by-32 UB.
- Count: cnt' = min(cnt + n, 32), saturating.
- Slot free this cycle: slot_free = !fifo_valid || fifo_ready. Accept and refill in the same cycle is allowed (pass-through).
- States: IDLE (fifo_valid=0) and FULL (fifo_valid=1). IDLE->FULL on push. FULL->IDLE on fifo_ready with no new push. FULL->FULL on fifo_ready together with a new push.
- IN without autopush (cfg_autoPush=0 or cnt'<T): ISR and count update next edge; stall=0.
- IN with autopush (cfg_autoPush=1 and cnt'>=T):
  - slot_free: fifo_data<=isr', fifo_valid<=1, isr<=0, cnt<=0.
  - otherwise: stall=1 (combinational); ISR, count and output unchanged.
- PUSH:
  - slot_free: fifo_data<=isr, fifo_valid<=1, isr<=0, cnt<=0.
  - occupied and push_block=1: stall=1, no state change.
  - occupied and push_block=0: word dropped, isr<=0, cnt<=0, stall=0.
- Priority: clear > in_valid > push_req. Clear zeroes isr and count only; pending output word unaffected. push_req is ignored when in_valid=1.
- fifo_data/fifo_valid are registered: word appears the cycle after the push. fifo_valid stays high, data stable, until fifo_ready.
- stall depends only on current inputs and state; never asserted when in_valid=push_req=0.

Optional Feature:
PIO_ISR_DROP_COUNT_EN:
- Defined: adds output drop_count (16 bits). Increments by 1 on each non-blocking PUSH discarded with buffer occupied; saturates at 0xFFFF; reset to 0; cleared by clear.
- Undefined: port and counter absent; drops are silent.

Test Plan:
- Shift left, no autopush: in_count=8, pin_data 0xAB then 0xCD -> isr_value=0xABCD, isr_count=16, fifo_valid=0.
- Shift right, autopush, T=8: in_count=4 with 0x3, then 0x5 -> second IN loads fifo_data=0x53000000 and fifo_valid=1 next cycle; isr_value=0, isr_count=0.
- Full-word IN, in_count=0 (32), pin_data 0xDEADBEEF, autopush T=0 -> fifo_data=0xDEADBEEF; count saturates/clears correctly.
- Backpressure: fifo_ready=0 with pending word, then autopush IN -> stall=1 for every held cycle, ISR unchanged. Raise fifo_ready -> same-cycle pass-through, new word valid next cycle, stall drops.
- Non-blocking PUSH with buffer occupied -> isr cleared, fifo_data unchanged; drop_count=1 when PIO_ISR_DROP_COUNT_EN is defined.
- Reset asserted mid-handshake (fifo_valid=1, isr=0x1234) -> all outputs 0 immediately without a clock edge; clear with in_valid=1 -> isr_value=0.
